dual_alu_2to3: RTL and testbench

// - Two independent 4-bit ALU lanes plus a third "sum-of-results" lane: 2 operand pairs in, 3 results out.
// - Sits in the Caravel user project area; operands/selects arrive on mprj_io[37:18], results drive mprj_io[17:4] and mprj_io[0].
// - Results are registered; firmware only configures GPIO directions, the datapath is purely pin-driven.

---
 rtl/dual_alu_2to3_if.sv | 31 +++
 rtl/dual_alu_2to3.sv | 110 +++++++++++
 tb/tb_dual_alu_2to3.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dual_alu_2to3_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_alu_2to3_if
// Brief    : Pin-level bundle for the dual ALU: enable, operands, opcodes,
//            packed result and pad output-enable-bar.
// Revision : 1.0 - initial release
// ============================================================================
interface dual_alu_2to3_if #(
  parameter int WIDTH = 4
);
  logic                     en;
  logic [WIDTH-1:0]         a0;
  logic [WIDTH-1:0]         b0;
  logic [WIDTH-1:0]         a1;
  logic [WIDTH-1:0]         b1;
  logic [1:0]               alu_sel1;
  logic [1:0]               alu_sel2;
  logic [3*(WIDTH+1)-1:0]   result;
  logic [37:0]              io_oeb;

  modport master (
    output en, a0, b0, a1, b1, alu_sel1, alu_sel2,
    input  result, io_oeb
  );

  modport slave (
    input  en, a0, b0, a1, b1, alu_sel1, alu_sel2,
    output result, io_oeb
  );
endinterface
`default_nettype wire

// File: rtl/dual_alu_2to3.sv
`default_nettype none
// ============================================================================
// Module   : dual_alu_2to3
// Brief    : Two 4-bit ALU lanes plus a wrapping sum lane, registered output.
//            Optional input register stage enabled by DUAL_ALU_INREG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dual_alu_2to3 #(
  parameter int WIDTH = 4
) (
  input  wire logic          wb_clk_i,
  input  wire logic          wb_rst_i,
  dual_alu_2to3_if.slave     bus
);

  localparam int          c_RW       = WIDTH + 1;
  // Pads 17:4 and 0 are outputs (oeb=0); every other pad stays an input.
  localparam logic [37:0] c_IO_OEB   = 38'h3F_FFFC_000E;

  localparam logic [1:0]  c_OP_ADD   = 2'b00;
  localparam logic [1:0]  c_OP_SUB   = 2'b01;
  localparam logic [1:0]  c_OP_AND   = 2'b10;

  logic [WIDTH-1:0]  w_a0;
  logic [WIDTH-1:0]  w_b0;
  logic [WIDTH-1:0]  w_a1;
  logic [WIDTH-1:0]  w_b1;
  logic [1:0]        w_sel1;
  logic [1:0]        w_sel2;
  logic [c_RW-1:0]   w_r0;
  logic [c_RW-1:0]   w_r1;
  logic [c_RW-1:0]   w_r2;
  logic [3*c_RW-1:0] r_result;

  function automatic logic [c_RW-1:0] lane_alu(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       sel
  );
    logic [c_RW-1:0] ea;
    logic [c_RW-1:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (sel)
      c_OP_ADD: lane_alu = ea + eb;
      c_OP_SUB: lane_alu = ea - eb;
      c_OP_AND: lane_alu = ea & eb;
      default:  lane_alu = ea ^ eb;
    endcase
  endfunction

`ifdef DUAL_ALU_INREG_EN
  logic [WIDTH-1:0] r_a0;
  logic [WIDTH-1:0] r_b0;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  logic [1:0]       r_sel1;
  logic [1:0]       r_sel2;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_a0   <= '0;
      r_b0   <= '0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_sel1 <= '0;
      r_sel2 <= '0;
    end else if (bus.en) begin
      r_a0   <= bus.a0;
      r_b0   <= bus.b0;
      r_a1   <= bus.a1;
      r_b1   <= bus.b1;
      r_sel1 <= bus.alu_sel1;
      r_sel2 <= bus.alu_sel2;
    end
  end

  assign w_a0   = r_a0;
  assign w_b0   = r_b0;
  assign w_a1   = r_a1;
  assign w_b1   = r_b1;
  assign w_sel1 = r_sel1;
  assign w_sel2 = r_sel2;
`else
  assign w_a0   = bus.a0;
  assign w_b0   = bus.b0;
  assign w_a1   = bus.a1;
  assign w_b1   = bus.b1;
  assign w_sel1 = bus.alu_sel1;
  assign w_sel2 = bus.alu_sel2;
`endif

  // The sum lane is fed from this cycle's lane values so all fields agree.
  assign w_r0 = lane_alu(w_a0, w_b0, w_sel1);
  assign w_r1 = lane_alu(w_a1, w_b1, w_sel2);
  assign w_r2 = w_r0 + w_r1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_result <= '0;
    end else if (bus.en) begin
      r_result <= {w_r2, w_r1, w_r0};
    end
  end

  assign bus.result = r_result;
  assign bus.io_oeb = c_IO_OEB;

endmodule
`default_nettype wire

// File: tb/tb_dual_alu_2to3.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_alu_2to3
// Brief    : Scoreboard bench for dual_alu_2to3 (either pipeline depth).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_alu_2to3;

`ifdef DUAL_ALU_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [14:0] exp_q[$];
  logic [14:0] last_exp;

  dual_alu_2to3_if #(.WIDTH(4)) bus ();

  dual_alu_2to3 #(.WIDTH(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] lane(input int a, input int b, input int sel);
    int v;
    case (sel)
      0:       v = a + b;
      1:       v = (a - b + 32) % 32;
      2:       v = a & b;
      default: v = a ^ b;
    endcase
    return 5'(v);
  endfunction

  function automatic logic [14:0] model(input int a0, input int b0, input int s1,
                                        input int a1, input int b1, input int s2);
    int r0;
    int r1;
    r0 = int'(lane(a0, b0, s1));
    r1 = int'(lane(a1, b1, s2));
    return {5'((r0 + r1) % 32), 5'(r1), 5'(r0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic restart_queue();
    exp_q.delete();
    for (int k = 1; k < LAT; k++) exp_q.push_back(15'h0000);
    last_exp = 15'h0000;
  endtask

  task automatic step(input int a0, input int b0, input int s1,
                      input int a1, input int b1, input int s2, input string tag);
    logic [14:0] e;
    @(negedge clk);
    bus.en       = 1'b1;
    bus.a0       = 4'(a0);
    bus.b0       = 4'(b0);
    bus.alu_sel1 = 2'(s1);
    bus.a1       = 4'(a1);
    bus.b1       = 4'(b1);
    bus.alu_sel2 = 2'(s2);
    exp_q.push_back(model(a0, b0, s1, a1, b1, s2));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check(tag, 64'(bus.result), 64'(e));
    end
  endtask

  // Repeats a vector until it reaches the output, regardless of depth.
  task automatic step_through(input int a0, input int b0, input int s1,
                              input int a1, input int b1, input int s2, input string tag);
    for (int k = 0; k < LAT; k++) step(a0, b0, s1, a1, b1, s2, tag);
  endtask

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.a0       = 4'd7;
    bus.b0       = 4'd3;
    bus.a1       = 4'd11;
    bus.b1       = 4'd5;
    bus.alu_sel1 = 2'd0;
    bus.alu_sel2 = 2'd1;
    #1 rst = 1'b1;
    #1;
    check("reset_async", 64'(bus.result), 64'h0);
    check("io_oeb_reset", 64'(bus.io_oeb), 64'h3F_FFFC_000E);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 64'(bus.result), 64'h0);

    @(negedge clk);
    rst = 1'b0;
    restart_queue();

    step_through(9, 9, 0, 0, 0, 0, "add");
    check("add_literal", 64'(bus.result), 64'(15'b10010_00000_10010));
    step_through(3, 5, 1, 15, 15, 0, "sub_wrap");
    check("sub_literal", 64'(bus.result), 64'(15'b11100_11110_11110));
    step_through(12, 10, 2, 12, 10, 3, "logic");
    check("logic_literal", 64'(bus.result), 64'(15'b01110_00110_01000));
    step(15, 15, 0, 0, 15, 1, "add_max_sub_min");
    step(0, 0, 1, 15, 0, 3, "sub_zero_xor");

    for (int i = 0; i < 20; i++) begin
      step(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)),
           int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)),
           "random");
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.en       = 1'b0;
      bus.a0       = 4'($urandom);
      bus.b0       = 4'($urandom);
      bus.a1       = 4'($urandom);
      bus.b1       = 4'($urandom);
      bus.alu_sel1 = 2'($urandom);
      bus.alu_sel2 = 2'($urandom);
      @(posedge clk);
      #1;
      check("hold", 64'(bus.result), 64'(last_exp));
    end
    step(6, 4, 1, 8, 9, 0, "resume");
    step(5, 10, 3, 1, 2, 1, "resume2");

    check("io_oeb_run", 64'(bus.io_oeb), 64'h3F_FFFC_000E);

    @(negedge clk);
    bus.en = 1'b1;
    bus.a0 = 4'd14;
    bus.b0 = 4'd13;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_midop", 64'(bus.result), 64'h0);
    @(posedge clk);
    #1;
    check("reset_midop_held", 64'(bus.result), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    restart_queue();
    step(9, 9, 0, 0, 0, 0, "post_reset1");
    step(10, 3, 2, 7, 7, 1, "post_reset2");
    step(1, 1, 0, 2, 2, 0, "post_reset3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
